// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl
// -----------------------------------------------------------------------------
// Time-multiplexing scan controller for a four-digit common-anode
// seven-segment display that shares a single hex-to-segment decoder.
//
// The controller steps through the digits one slot at a time. Each slot lasts
// REFRESH_DIV cycles. The first BLANK_CYCLES cycles of a slot keep every anode
// off, which suppresses ghosting between digits. During that blank time, x
// already carries the next digit's nibble so the decoder output has settled
// before the anode turns on.
//
// Host writes land in a shadow register. The shadow is copied into the display
// register only on the last cycle of a frame (dig=3, cnt=REFRESH_DIV-1), so a
// frame never shows a mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (blank time plus show time)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (< REFRESH_DIV)
//
// Optional feature:
//   SEV_SEG_LZB_EN  when defined, enables leading-zero blanking. During SHOW,
//                   digit k (3..1) stays dark if display nibbles k..3 and
//                   dp bits k..3 are all zero. Digit 0 is always shown.
//
// Ports:
//   clk         system clock; everything is on the rising edge
//   rst         synchronous active-high reset
//   value[15:0] hex value; [3:0] drives an[0] (rightmost digit)
//   dp_in[3:0]  decimal-point request per digit, 1 = lit
//   load        one-cycle strobe that captures value and dp_in into the shadow
//   pending     high while a shadow value is waiting to be committed
//   frame_tick  one-cycle pulse on the frame-boundary (commit) cycle
//   x[3:0]      nibble to the shared decoder
//   an[3:0]     anodes, active low; at most one bit low at a time
//   dp          decimal point, active low
// -----------------------------------------------------------------------------
module sev_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_tick,
  output logic [3:0]  x,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  // State registers
  logic [CW-1:0] cnt_reg,        cnt_next;
  logic [1:0]    dig_reg,        dig_next;
  logic [15:0]   shadow_val_reg, shadow_val_next;
  logic [3:0]    shadow_dp_reg,  shadow_dp_next;
  logic [15:0]   disp_val_reg,   disp_val_next;
  logic [3:0]    disp_dp_reg,    disp_dp_next;
  logic          pending_reg,    pending_next;

  // Output registers
  logic          frame_tick_reg, frame_tick_next;
  logic [3:0]    an_reg,         an_next;
  logic [3:0]    x_reg,          x_next;
  logic          dp_reg,         dp_next;

  logic          slot_end;
  logic          frame_end;
  logic          in_blank_next;
  phase_t        phase_next;
  logic [3:0]    lz_next;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (dig_reg == 2'd3);

  // ---------------------------------------------------------------------------
  // Counters, shadow and display registers
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_next        = slot_end ? '0 : cnt_reg + 1'b1;
    dig_next        = slot_end ? dig_reg + 2'd1 : dig_reg;

    // Commit uses the shadow as it was before any load on this same cycle.
    disp_val_next   = disp_val_reg;
    disp_dp_next    = disp_dp_reg;
    if (frame_end && pending_reg) begin
      disp_val_next = shadow_val_reg;
      disp_dp_next  = shadow_dp_reg;
    end

    shadow_val_next = shadow_val_reg;
    shadow_dp_next  = shadow_dp_reg;
    pending_next    = pending_reg;
    if (frame_end) begin
      pending_next  = 1'b0;
    end
    // A load always wins over the commit-clear, so a load on the boundary
    // cycle stays pending for the following frame.
    if (load) begin
      shadow_val_next = value;
      shadow_dp_next  = dp_in;
      pending_next    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase of the upcoming cycle. The outputs are registered from next-state
  // values so they line up with cnt/dig of the cycle they are visible in.
  // ---------------------------------------------------------------------------
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_next = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
      assign in_blank_next = (cnt_next < BLANK_END);
    end
  endgenerate

  assign phase_next = in_blank_next ? PH_BLANK : PH_SHOW;

  // ---------------------------------------------------------------------------
  // Leading-zero mask: lz_next[k] = 1 means digit k stays dark during SHOW.
  // ---------------------------------------------------------------------------
  assign lz_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
`ifdef SEV_SEG_LZB_EN
      assign lz_next[gi] = (disp_val_next[15:4*gi] == '0) &&
                           (disp_dp_next[3:gi] == '0);
`else
      assign lz_next[gi] = 1'b0;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    x_next          = disp_val_next[{dig_next, 2'b00} +: 4];
    an_next         = 4'b1111;
    dp_next         = 1'b1;
    frame_tick_next = (cnt_next == CNT_LAST) && (dig_next == 2'd3);
    if ((phase_next == PH_SHOW) && !lz_next[dig_next]) begin
      an_next = ~(4'b0001 << dig_next);
      dp_next = ~disp_dp_next[dig_next];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      dig_reg        <= 2'd0;
      shadow_val_reg <= 16'h0000;
      shadow_dp_reg  <= 4'h0;
      disp_val_reg   <= 16'h0000;
      disp_dp_reg    <= 4'h0;
      pending_reg    <= 1'b0;
      frame_tick_reg <= 1'b0;
      an_reg         <= 4'b1111;
      x_reg          <= 4'h0;
      dp_reg         <= 1'b1;
    end else begin
      cnt_reg        <= cnt_next;
      dig_reg        <= dig_next;
      shadow_val_reg <= shadow_val_next;
      shadow_dp_reg  <= shadow_dp_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      pending_reg    <= pending_next;
      frame_tick_reg <= frame_tick_next;
      an_reg         <= an_next;
      x_reg          <= x_next;
      dp_reg         <= dp_next;
    end
  end

  assign pending    = pending_reg;
  assign frame_tick = frame_tick_reg;
  assign an         = an_reg;
  assign x          = x_reg;
  assign dp         = dp_reg;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Testbench for sev_seg_scan_ctrl (REFRESH_DIV=8, BLANK_CYCLES=2).
// The driver loads values and pushes the per-slot display it expects into a
// queue. The monitor follows its own cycle count since reset, pops the entry
// for the current frame/slot and compares the blank and show phases.
module tb_sev_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
`ifdef SEV_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  x;
  logic [3:0]  an;
  logic        dp;

  sev_seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .pending   (pending),
    .frame_tick(frame_tick),
    .x         (x),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the expected slot position.
  int t;
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         f;
    int         s;
    logic [3:0] an;
    logic [3:0] x;
    logic       dp;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end else begin
      $display("[TB] ok %s = %h (t=%0d)", name, act, t);
    end
  endtask

  // Expected display of one frame, slots 0..nslots-1.
  task automatic push_frame(input int f, input logic [15:0] val, input logic [3:0] dpv,
                            input int nslots);
    exp_t e;
    logic blanked;
    for (int s = 0; s < nslots; s++) begin
      e.f = f;
      e.s = s;
      e.x = 4'((val >> (4 * s)) & 16'h000F);
      blanked = LZB && (s > 0) && ((val >> (4 * s)) == 16'h0000) && ((dpv >> s) == 4'h0);
      if (blanked) begin
        e.an = 4'b1111;
        e.dp = 1'b1;
      end else begin
        e.an = ~(4'b0001 << s);
        e.dp = ~dpv[s];
      end
      q.push_back(e);
    end
  endtask

  // Monitor
  int m_p, m_s, m_f;
  always @(negedge clk) begin
    if (!rst) begin
      m_p = t % RD;
      m_s = (t / RD) % 4;
      m_f = t / (4 * RD);
      chk($sformatf("frame_tick f%0d s%0d p%0d", m_f, m_s, m_p), {15'h0, frame_tick},
          {15'h0, (m_p == RD - 1) && (m_s == 3)});
      while (q.size() > 0 && (q[0].f < m_f || (q[0].f == m_f && q[0].s < m_s))) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed slot f%0d s%0d: got none expected check", q[0].f, q[0].s);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].f == m_f && q[0].s == m_s) begin
        if (m_p < BC) begin
          chk($sformatf("blank {an,x,dp} f%0d s%0d p%0d", m_f, m_s, m_p),
              {7'h0, an, x, dp}, {7'h0, 4'b1111, q[0].x, 1'b1});
        end
        if (m_p == BC || m_p == RD - 1) begin
          chk($sformatf("show {an,x,dp} f%0d s%0d p%0d", m_f, m_s, m_p),
              {7'h0, an, x, dp}, {7'h0, q[0].an, q[0].x, q[0].dp});
        end
        if (m_p == RD - 1) void'(q.pop_front());
      end
    end
  end

  task automatic wait_t(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (t != n && guard < 1000);
    if (t != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_t: got t=%0d expected t=%0d", t, n);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset an", {12'h0, an}, 16'h000F);
    chk("reset x/dp/pending/tick", {12'h0, x, dp, pending, frame_tick}, {12'h0, 4'h0, 1'b1, 1'b0, 1'b0});
    push_frame(0, 16'h0000, 4'h0, 4);
    rst = 1'b0;

    // Scan order with 1234
    wait_t(4);
    do_load(16'h1234, 4'h0);
    push_frame(1, 16'h1234, 4'h0, 4);
    chk("pending after load", {15'h0, pending}, 16'h0001);
    wait_t(32);
    chk("pending after commit 1234", {15'h0, pending}, 16'h0000);

    // Tear-free update: frame 1 keeps 1234, frame 2 shows ABCD
    wait_t(40);
    do_load(16'hABCD, 4'h0);
    push_frame(2, 16'hABCD, 4'h0, 4);
    chk("pending mid-frame", {15'h0, pending}, 16'h0001);
    wait_t(64);
    chk("pending after commit ABCD", {15'h0, pending}, 16'h0000);

    // Collision: 1111 pending, 5555 loaded on the boundary cycle
    wait_t(80);
    do_load(16'h1111, 4'h0);
    push_frame(3, 16'h1111, 4'h0, 4);
    wait_t(95);
    do_load(16'h5555, 4'h0);
    push_frame(4, 16'h5555, 4'h0, 4);
    chk("pending kept after collision", {15'h0, pending}, 16'h0001);
    wait_t(128);
    chk("pending after commit 5555", {15'h0, pending}, 16'h0000);

    // Decimal point on digit 2 only
    wait_t(130);
    do_load(16'h1234, 4'b0100);
    push_frame(5, 16'h1234, 4'b0100, 4);

    // Leading zeros
    wait_t(170);
    do_load(16'h0042, 4'h0);
    push_frame(6, 16'h0042, 4'h0, 4);
    push_frame(7, 16'h0042, 4'h0, 2);

    // Mid-slot reset during dig=2 SHOW with a value pending
    wait_t(242);
    do_load(16'hFFFF, 4'hF);
    chk("pending before mid reset", {15'h0, pending}, 16'h0001);
    wait_t(244);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset an", {12'h0, an}, 16'h000F);
    chk("mid reset x/dp/pending/tick", {12'h0, x, dp, pending, frame_tick}, {12'h0, 4'h0, 1'b1, 1'b0, 1'b0});
    push_frame(0, 16'h0000, 4'h0, 4);
    push_frame(1, 16'h0000, 4'h0, 4);
    rst = 1'b0;
    wait_t(5);
    chk("pending discarded by reset", {15'h0, pending}, 16'h0000);
    wait_t(70);

    chk("scoreboard drained", q.size(), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
